// File: rtl/iob_uart16550_ctrl_pkg.sv
// rtl/iob_uart16550_ctrl_pkg.sv - UART register map, controller states and init ROM
package iob_uart16550_ctrl_pkg;

  localparam logic [2:0] RBR_THR_DLL = 3'd0;
  localparam logic [2:0] IER_DLM     = 3'd1;
  localparam logic [2:0] IIR_FCR     = 3'd2;
  localparam logic [2:0] LCR         = 3'd3;
  localparam logic [2:0] MCR         = 3'd4;
  localparam logic [2:0] LSR         = 3'd5;

  localparam logic [7:0] LCR_DLAB   = 8'h80;
  localparam int         INIT_STEPS = 6;

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_FWD, ST_RDWAIT} state_t;

  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] data;
  } init_wr_t;

  // Divisor is loaded with DLAB set, then LCR is rewritten, which clears DLAB.
  function automatic init_wr_t init_rom(input logic [2:0]  step,
                                        input logic [15:0] div,
                                        input logic [7:0]  lcr_cfg,
                                        input logic [7:0]  fcr_cfg,
                                        input logic [7:0]  ier_cfg);
    init_wr_t w;
    case (step)
      3'd0:    w = '{addr: LCR,         data: LCR_DLAB};
      3'd1:    w = '{addr: RBR_THR_DLL, data: div[7:0]};
      3'd2:    w = '{addr: IER_DLM,     data: div[15:8]};
      3'd3:    w = '{addr: LCR,         data: lcr_cfg};
      3'd4:    w = '{addr: IIR_FCR,     data: fcr_cfg};
      default: w = '{addr: IER_DLM,     data: ier_cfg};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/iob_rr_arb2.sv
// rtl/iob_rr_arb2.sv - combinational 2-way round-robin arbiter
module iob_rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o,
  output logic       valid_o
);

  assign valid_o = |req_i;
  assign gnt_o   = (&req_i) ? ~last_i : req_i[1];

endmodule

// File: rtl/iob_uart16550_ctrl.sv
// rtl/iob_uart16550_ctrl.sv - UART init sequencer and 2-master IOb port arbiter
module iob_uart16550_ctrl
  import iob_uart16550_ctrl_pkg::*;
#(
  parameter int         ADDR_W  = 3,
  parameter int         DATA_W  = 32,
  parameter int         DIV_W   = 16,
  parameter logic [7:0] LCR_CFG = 8'h03,
  parameter logic [7:0] FCR_CFG = 8'h07,
  parameter logic [7:0] IER_CFG = 8'h00
) (
  input  logic                clk_i,
  input  logic                cke_i,
  input  logic                rst_i,
  input  logic [DIV_W-1:0]    cfg_div_i,
  input  logic                init_req_i,
  output logic                init_done_o,
  input  logic                m0_avalid_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_ready_o,
  output logic                m0_rvalid_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_avalid_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_ready_o,
  output logic                m1_rvalid_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  output logic                s_avalid_o,
  output logic [ADDR_W-1:0]   s_addr_o,
  output logic [DATA_W-1:0]   s_wdata_o,
  output logic [DATA_W/8-1:0] s_wstrb_o,
  input  logic                s_ready_i,
  input  logic                s_rvalid_i,
  input  logic [DATA_W-1:0]   s_rdata_i
);

  localparam int STRB_W = DATA_W / 8;

  state_t            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic              init_done_q, init_done_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              rr_last_q, rr_last_d;
  logic              gnt_q, gnt_d;
  logic              pend_q, pend_d;

  logic              arb_gnt, arb_valid;
  init_wr_t          rom;
  logic              g_avalid;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;
  logic [STRB_W-1:0] g_wstrb;

  iob_rr_arb2 u_arb (
    .req_i   ({m1_avalid_i, m0_avalid_i}),
    .last_i  (rr_last_q),
    .gnt_o   (arb_gnt),
    .valid_o (arb_valid)
  );

  assign rom      = init_rom(step_q, div_q[15:0], LCR_CFG, FCR_CFG, IER_CFG);
  assign g_avalid = gnt_q ? m1_avalid_i : m0_avalid_i;
  assign g_addr   = gnt_q ? m1_addr_i   : m0_addr_i;
  assign g_wdata  = gnt_q ? m1_wdata_i  : m0_wdata_i;
  assign g_wstrb  = gnt_q ? m1_wstrb_i  : m0_wstrb_i;
  assign init_done_o = init_done_q;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    init_done_d = init_done_q;
    div_d       = div_q;
    rr_last_d   = rr_last_q;
    gnt_d       = gnt_q;
    pend_d      = pend_q;
    s_avalid_o  = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_wstrb_o   = '0;
    m0_ready_o  = 1'b0;
    m1_ready_o  = 1'b0;
    m0_rvalid_o = 1'b0;
    m1_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_rdata_o  = '0;

    case (state_q)
      ST_INIT: begin
        s_avalid_o = 1'b1;
        s_addr_o   = ADDR_W'(rom.addr);
        s_wdata_o  = DATA_W'(rom.data) << {rom.addr[1:0], 3'b000};
        s_wstrb_o  = STRB_W'(1) << rom.addr[1:0];
        if (s_ready_i) begin
          if (step_q == 3'(INIT_STEPS - 1)) begin
            state_d     = ST_IDLE;
            step_d      = '0;
            init_done_d = 1'b1;
          end else begin
            step_d = step_q + 3'd1;
          end
        end
      end
      ST_IDLE: begin
        if (pend_q || init_req_i) begin
          state_d     = ST_INIT;
          step_d      = '0;
          init_done_d = 1'b0;
          div_d       = cfg_div_i;
          pend_d      = 1'b0;
        end else if (arb_valid) begin
          gnt_d     = arb_gnt;
          rr_last_d = arb_gnt;
          state_d   = ST_FWD;
        end
      end
      ST_FWD: begin
        s_avalid_o = g_avalid;
        s_addr_o   = g_addr;
        s_wdata_o  = g_wdata;
        s_wstrb_o  = g_wstrb;
        m0_ready_o = ~gnt_q & s_ready_i & cke_i;
        m1_ready_o =  gnt_q & s_ready_i & cke_i;
        pend_d     = pend_q | init_req_i;
        if (g_avalid && s_ready_i) begin
          state_d = (g_wstrb != '0) ? ST_IDLE : ST_RDWAIT;
        end
      end
      default: begin
        pend_d = pend_q | init_req_i;
        if (s_rvalid_i) begin
          m0_rvalid_o = ~gnt_q & cke_i;
          m1_rvalid_o =  gnt_q & cke_i;
          m0_rdata_o  = gnt_q ? '0 : s_rdata_i;
          m1_rdata_o  = gnt_q ? s_rdata_i : '0;
          state_d     = ST_IDLE;
        end
      end
    endcase

    // Nothing may be handed out while reset is held; the UART is being reset too.
    if (rst_i) begin
      s_avalid_o  = 1'b0;
      m0_ready_o  = 1'b0;
      m1_ready_o  = 1'b0;
      m0_rvalid_o = 1'b0;
      m1_rvalid_o = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_INIT;
      step_q      <= '0;
      init_done_q <= 1'b0;
      div_q       <= cfg_div_i;
      rr_last_q   <= 1'b1;
      gnt_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else if (cke_i) begin
      state_q     <= state_d;
      step_q      <= step_d;
      init_done_q <= init_done_d;
      div_q       <= div_d;
      rr_last_q   <= rr_last_d;
      gnt_q       <= gnt_d;
      pend_q      <= pend_d;
    end
  end

endmodule

// File: tb/tb_iob_uart16550_ctrl.sv
// tb/tb_iob_uart16550_ctrl.sv - scoreboard bench for the UART init/arbitration controller
module tb_iob_uart16550_ctrl;

  typedef struct packed {
    logic [1:0]  src;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } xfer_t;

  typedef struct packed {
    logic [1:0]  who;
    logic [31:0] data;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst, cke, init_req, slv_ready, rsp_v, stray_v;
  logic [15:0] cfg_div;
  logic        init_done;
  logic [1:0]  m_avalid, m_ready, m_rvalid;
  logic [2:0]  m_addr  [2];
  logic [31:0] m_wdata [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_rdata [2];
  logic        s_avalid;
  logic [2:0]  s_addr;
  logic [31:0] s_wdata, s_rdata;
  logic [3:0]  s_wstrb;

  xfer_t exp_slv[$];
  rsp_t  exp_rsp[$];
  int    total = 0, bad = 0;
  int    cyc_n = 0, rsp_cyc = 0, m0_xfer_cyc = 0;
  int    rd_lat = 3;
  logic [31:0] rsp_data;

  always #5 clk = ~clk;

  iob_uart16550_ctrl dut (
    .clk_i(clk), .cke_i(cke), .rst_i(rst), .cfg_div_i(cfg_div),
    .init_req_i(init_req), .init_done_o(init_done),
    .m0_avalid_i(m_avalid[0]), .m0_addr_i(m_addr[0]), .m0_wdata_i(m_wdata[0]),
    .m0_wstrb_i(m_wstrb[0]), .m0_ready_o(m_ready[0]), .m0_rvalid_o(m_rvalid[0]),
    .m0_rdata_o(m_rdata[0]),
    .m1_avalid_i(m_avalid[1]), .m1_addr_i(m_addr[1]), .m1_wdata_i(m_wdata[1]),
    .m1_wstrb_i(m_wstrb[1]), .m1_ready_o(m_ready[1]), .m1_rvalid_o(m_rvalid[1]),
    .m1_rdata_o(m_rdata[1]),
    .s_avalid_o(s_avalid), .s_addr_o(s_addr), .s_wdata_o(s_wdata), .s_wstrb_o(s_wstrb),
    .s_ready_i(slv_ready), .s_rvalid_i(rsp_v | stray_v), .s_rdata_i(s_rdata)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: bound expired or unexpected event", nm);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference init sequence: register/value pairs, then byte-lane placement by address.
  task automatic push_init(input logic [15:0] div);
    logic [2:0] a [6];
    logic [7:0] b [6];
    int lane;
    a = '{3'd3, 3'd0, 3'd1, 3'd3, 3'd2, 3'd1};
    b = '{8'h80, div[7:0], div[15:8], 8'h03, 8'h07, 8'h00};
    for (int i = 0; i < 6; i++) begin
      lane = int'(a[i]) % 4;
      exp_slv.push_back('{src: 2'd0, addr: a[i], wdata: 32'(b[i]) << (8 * lane),
                          wstrb: 4'(1 << lane)});
    end
  endtask

  task automatic mreq(input int k, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    m_avalid[k] = 1'b1;
    m_addr[k]   = a;
    m_wdata[k]  = d;
    m_wstrb[k]  = s;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (m_ready[k]) begin
        @(posedge clk);
        #1;
        m_avalid[k] = 1'b0;
        return;
      end
    end
    m_avalid[k] = 1'b0;
    fail_now("mreq_timeout");
  endtask

  task automatic wait_done();
    for (int c = 0; c < 200; c++) begin
      if (init_done) return;
      cyc(1);
    end
    fail_now("init_done_timeout");
  endtask

  task automatic drain();
    for (int c = 0; c < 500; c++) begin
      if (exp_slv.size() == 0 && exp_rsp.size() == 0) return;
      cyc(1);
    end
    fail_now("drain_timeout");
  endtask

  // Slave read responder: answers each accepted read rd_lat cycles later.
  initial begin
    int  pend_cnt;
    logic rd_seen;
    pend_cnt = 0;
    rsp_v    = 1'b0;
    forever begin
      @(negedge clk);
      rd_seen = !rst && cke && s_avalid && slv_ready && (s_wstrb == 4'b0);
      @(posedge clk);
      #1;
      rsp_v = 1'b0;
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          rsp_v   = 1'b1;
          s_rdata = rsp_data;
        end
      end
      if (rd_seen) pend_cnt = rd_lat;
    end
  end

  // Monitor: every accepted slave request and every master read response is popped and compared.
  logic  prev_hold = 1'b0;
  logic [38:0] prev_req;
  always @(negedge clk) begin
    logic  xfer;
    xfer_t got, e;
    rsp_t  r;
    cyc_n++;
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      xfer = s_avalid && slv_ready && cke;
      chk("ready_exclusive", 64'(&m_ready), 64'd0);
      if (!xfer) chk("ready_without_xfer", 64'(m_ready), 64'd0);
      if (prev_hold && s_avalid) chk("req_stable", 64'({s_addr, s_wdata, s_wstrb}), 64'(prev_req));
      if (xfer) begin
        got = '{src: m_ready[1] ? 2'd2 : (m_ready[0] ? 2'd1 : 2'd0),
                addr: s_addr, wdata: s_wdata, wstrb: s_wstrb};
        if (exp_slv.size() == 0) fail_now("xfer_unexpected");
        else begin
          e = exp_slv.pop_front();
          chk("slave_xfer", 64'(got), 64'(e));
        end
        if (got.src == 2'd1) m0_xfer_cyc = cyc_n;
      end
      prev_hold = s_avalid && !xfer;
      prev_req  = {s_addr, s_wdata, s_wstrb};
      if (|m_rvalid) begin
        rsp_cyc = cyc_n;
        if (exp_rsp.size() == 0) fail_now("rvalid_unexpected");
        else begin
          r = exp_rsp.pop_front();
          chk("read_rsp", 64'({m_rvalid, m_rvalid[1] ? m_rdata[1] : m_rdata[0]}), 64'(r));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [15:0] d2, d3;
    logic [2:0]  wa [2][4];
    logic [31:0] wd [2][4];
    logic [3:0]  ws [2][4];
    logic [2:0]  a6;
    logic [31:0] d6;
    logic [3:0]  s6;
    rst = 1'b1; cke = 1'b1; init_req = 1'b0; slv_ready = 1'b1; stray_v = 1'b0;
    cfg_div = 16'h0145; rsp_data = '0; s_rdata = '0; m_avalid = '0;
    for (int k = 0; k < 2; k++) begin
      m_addr[k] = '0; m_wdata[k] = '0; m_wstrb[k] = '0;
    end
    cyc(2);
    chk("rst_init_done", 64'(init_done), 64'd0);
    chk("rst_s_avalid", 64'(s_avalid), 64'd0);
    chk("rst_ready", 64'(m_ready), 64'd0);
    chk("rst_rvalid", 64'(m_rvalid), 64'd0);

    // Boot init: six back-to-back writes, done on the following cycle.
    push_init(16'h0145);
    rst = 1'b0;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (init_done) break;
        n++;
      end
      chk("init_cycles", 64'(n), 64'd6);
    end
    cyc(1);
    chk("init_q_empty", 64'(exp_slv.size()), 64'd0);

    // Re-init with a stall on the DLM write, then a clock-enable hold.
    d2 = 16'($urandom);
    cfg_div = d2;
    push_init(d2);
    init_req = 1'b1;
    cyc(1);
    init_req = 1'b0;
    chk("reinit_done_low", 64'(init_done), 64'd0);
    for (int c = 0; c < 20; c++) begin
      if (s_avalid && s_addr == 3'd1) break;
      cyc(1);
    end
    slv_ready = 1'b0;
    cyc(5);
    chk("stall_dlm", 64'({s_addr, s_wdata, s_wstrb}), 64'({3'd1, 32'(d2[15:8]) << 8, 4'b0010}));
    slv_ready = 1'b1;
    cke = 1'b0;
    cyc(2);
    chk("cke_hold_dlm", 64'({s_addr, s_wdata, s_wstrb}), 64'({3'd1, 32'(d2[15:8]) << 8, 4'b0010}));
    cke = 1'b1;
    wait_done();
    drain();

    // Both masters write continuously: grants alternate starting with m0.
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        wa[k][i] = 3'($urandom);
        wd[k][i] = $urandom;
        ws[k][i] = 4'($urandom_range(1, 15));
      end
      exp_slv.push_back('{src: 2'd1, addr: wa[0][i], wdata: wd[0][i], wstrb: ws[0][i]});
      exp_slv.push_back('{src: 2'd2, addr: wa[1][i], wdata: wd[1][i], wstrb: ws[1][i]});
    end
    fork
      begin for (int i = 0; i < 4; i++) mreq(0, wa[0][i], wd[0][i], ws[0][i]); end
      begin for (int i = 0; i < 4; i++) mreq(1, wa[1][i], wd[1][i], ws[1][i]); end
    join
    drain();

    // m1 reads LSR while m0 waits to write THR.
    rd_lat = 3;
    rsp_data = 32'h0000_6000;
    d6 = $urandom;
    exp_slv.push_back('{src: 2'd2, addr: 3'd5, wdata: 32'd0, wstrb: 4'd0});
    exp_rsp.push_back('{who: 2'b10, data: 32'h0000_6000});
    exp_slv.push_back('{src: 2'd1, addr: 3'd0, wdata: d6, wstrb: 4'b0001});
    fork
      mreq(1, 3'd5, 32'd0, 4'd0);
      begin cyc(1); mreq(0, 3'd0, d6, 4'b0001); end
    join
    drain();
    chk("m0_after_rsp", 64'(m0_xfer_cyc > rsp_cyc), 64'd1);

    // init request while a read is outstanding: read completes, then re-init.
    rd_lat = 4;
    rsp_data = $urandom;
    d3 = 16'($urandom);
    exp_slv.push_back('{src: 2'd1, addr: 3'd5, wdata: 32'd0, wstrb: 4'd0});
    exp_rsp.push_back('{who: 2'b01, data: rsp_data});
    push_init(d3);
    mreq(0, 3'd5, 32'd0, 4'd0);
    cfg_div = d3;
    init_req = 1'b1;
    cyc(1);
    init_req = 1'b0;
    chk("done_in_rdwait", 64'(init_done), 64'd1);
    for (int c = 0; c < 30; c++) begin
      if (s_avalid) break;
      cyc(1);
    end
    cfg_div = 16'($urandom);
    chk("done_low_in_init", 64'(init_done), 64'd0);
    wait_done();
    drain();
    stray_v = 1'b1;
    s_rdata = $urandom;
    #1;
    chk("stray_rvalid", 64'(m_rvalid), 64'd0);
    cyc(1);
    stray_v = 1'b0;

    // Reset while m0 is stalled in the forward phase.
    slv_ready = 1'b0;
    a6 = 3'($urandom);
    d6 = $urandom;
    s6 = 4'($urandom_range(1, 15));
    fork
      mreq(0, a6, d6, s6);
    join_none
    cyc(2);
    chk("fwd_before_rst", 64'({s_avalid, s_addr, m_ready[0]}), 64'({1'b1, a6, 1'b0}));
    rst = 1'b1;
    push_init(cfg_div);
    exp_slv.push_back('{src: 2'd1, addr: a6, wdata: d6, wstrb: s6});
    cyc(1);
    rst = 1'b0;
    slv_ready = 1'b1;
    #1;
    chk("rst_step0", 64'({s_avalid, s_addr, s_wdata, s_wstrb, m_ready[0], init_done}),
        64'({1'b1, 3'd3, 32'h8000_0000, 4'b1000, 1'b0, 1'b0}));
    cyc(1);
    wait_done();
    drain();
    wait fork;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
